vram_write_sched: RTL



---
 rtl/vram_write_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/vram_write_sched.sv
// vram_write_sched: single VRAM write port shared by FIFO-buffered CPU screen
// stores and a full-screen fill engine. Define VRAM_SCHED_FILL_EN for fill.
module vram_write_sched #(
    parameter int DEPTH        = 4,
    parameter int SCREEN_BASE  = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int FILL_SLOT    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        writeM,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        fill_start,
    input  logic [15:0] fill_data,
    output logic [15:0] vram_write_addr,
    output logic [15:0] vram_write_data,
    output logic        vram_write_en,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] LO = 17'(SCREEN_BASE);
    localparam logic [16:0] HI = 17'(SCREEN_BASE + SCREEN_WORDS);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic        hit, full, empty, push, pop;
    logic        cpu_req, cpu_gnt, fill_gnt;
    logic [31:0] head, in_word;
    logic [15:0] fill_addr, fill_word;

    assign hit = writeM
               && ({1'b0, addressM} >= LO)
               && ({1'b0, addressM} < HI);
    assign in_word = {addressM - 16'(SCREEN_BASE), outM};
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // An incoming hit is eligible the same cycle so an idle port has 1-cycle latency.
    assign cpu_req = !empty || (hit && !full);
    assign head    = empty ? in_word : mem_q[rd_ptr_q];

`ifdef VRAM_SCHED_FILL_EN
    localparam int SW = (FILL_SLOT > 1) ? $clog2(FILL_SLOT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(FILL_SLOT - 1);
    localparam logic [15:0] LAST = 16'(SCREEN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   off_q, off_d;
    logic [15:0]   fdata_q, fdata_d;
    logic [SW-1:0] starv_q, starv_d;
    logic          fill_req;

    // Fill FSM, starvation counter and the port grant decision.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        fdata_d   = fdata_q;
        starv_d   = '0;
        fill_addr = off_q;
        fill_word = fdata_q;
        fill_req  = (state_q == S_FILL)
                 || ((state_q == S_IDLE) && fill_start);
        fill_gnt  = fill_req && ((starv_q == STARVE_MAX) || !cpu_req);
        cpu_gnt   = cpu_req && !fill_gnt;
        if (fill_req && !fill_gnt) begin
            starv_d = starv_q + SW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    fdata_d   = fill_data;
                    fill_addr = '0;
                    fill_word = fill_data;
                    off_d     = fill_gnt ? 16'd1 : 16'd0;
                    state_d   = (fill_gnt && (LAST == '0)) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (fill_gnt) begin
                    off_d = off_q + 16'd1;
                    if (off_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                off_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                off_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // Fill engine state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            fdata_q <= '0;
            starv_q <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            fdata_q <= fdata_d;
            starv_q <= starv_d;
        end
    end
`else
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_data};

    // Without the fill engine the port serves the CPU FIFO only.
    always_comb begin
        fill_gnt  = 1'b0;
        cpu_gnt   = cpu_req;
        fill_addr = '0;
        fill_word = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
    end
`endif

    // FIFO bookkeeping and the word presented to VRAM next cycle.
    always_comb begin
        push     = hit && !full && !(empty && cpu_gnt);
        pop      = cpu_gnt && !empty;
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q
                 + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};
        en_d     = cpu_gnt || fill_gnt;
        addr_d   = '0;
        data_d   = '0;
        if (cpu_gnt) begin
            addr_d = head[31:16];
            data_d = head[15:0];
        end else if (fill_gnt) begin
            addr_d = fill_addr;
            data_d = fill_word;
        end
        ovf_d = ovf_q || (hit && full);
    end

    // FIFO storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // FIFO pointers and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign vram_write_addr = addr_q;
    assign vram_write_data = data_q;
    assign vram_write_en   = en_q;
    assign fill_busy       = busy_q;
    assign fill_done       = done_q;
    assign overflow        = ovf_q;

endmodule
